// File: rtl/resp_window_checker.sv
// resp_window_checker: multi-channel trigger/response monitor with a
// programmable response window [MIN_DLY:MAX_DLY], overlapping attempt
// tracking, per-channel pass/fail pulses and a sticky fail flag.
// Optional build macro RESP_WINDOW_CHECKER_CNT_EN compiles in saturating
// attempt/pass/fail counters; without it the counter ports read 0.
module resp_window_checker #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned MIN_DLY  = 1,
    parameter int unsigned MAX_DLY  = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      clr,
    input  logic [CHANNELS-1:0]       trig,
    input  logic [CHANNELS-1:0]       resp,
    output logic [CHANNELS-1:0]       pass,
    output logic [CHANNELS-1:0]       fail,
    output logic                      fail_seen,
    output logic [CHANNELS*CNT_W-1:0] attempt_cnt,
    output logic [CHANNELS*CNT_W-1:0] pass_cnt,
    output logic [CHANNELS*CNT_W-1:0] fail_cnt
);

    // Bit k of a channel's age vector marks an open attempt of age k.
    logic [MAX_DLY-1:0] age_q [CHANNELS];
    logic [MAX_DLY-1:0] age_d [CHANNELS];
    logic [CHANNELS-1:0] pass_c;
    logic [CHANNELS-1:0] fail_c;

    // Advance every open attempt one edge and resolve the ones in the window.
    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            logic [MAX_DLY:0] adv;
            age_d[c]  = '0;
            pass_c[c] = 1'b0;
            fail_c[c] = 1'b0;
            adv       = {age_q[c], 1'b0};
            if (enable) begin
                age_d[c][0] = trig[c];
                for (int unsigned a = 1; a < MAX_DLY; a++) begin
                    age_d[c][a] = adv[a] & ~(resp[c] & (a >= MIN_DLY));
                end
                pass_c[c] = resp[c] & (|adv[MAX_DLY:MIN_DLY]);
                // At age MAX_DLY a response always passes, so only silence fails.
                fail_c[c] = adv[MAX_DLY] & ~resp[c];
            end
        end
    end

    // Age vectors, pass/fail pulses and the sticky fail flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) age_q[c] <= '0;
            pass      <= '0;
            fail      <= '0;
            fail_seen <= 1'b0;
        end else if (clr) begin
            for (int unsigned c = 0; c < CHANNELS; c++) age_q[c] <= '0;
            pass      <= '0;
            fail      <= '0;
            fail_seen <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) age_q[c] <= age_d[c];
            pass <= pass_c;
            fail <= fail_c;
            if (|fail_c) fail_seen <= 1'b1;
        end
    end

`ifdef RESP_WINDOW_CHECKER_CNT_EN
    localparam int unsigned PC_W = $clog2(MAX_DLY + 1);

    logic [PC_W-1:0] npass [CHANNELS];

    // Saturating add of a small per-edge event count.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cur,
                                                 input logic [PC_W-1:0]  inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cur} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Number of attempts passing on each channel at this edge.
    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            npass[c] = '0;
            for (int unsigned a = MIN_DLY; a <= MAX_DLY; a++) begin
                if (enable && resp[c] && age_q[c][a-1]) npass[c] = npass[c] + PC_W'(1);
            end
        end
    end

    // Saturating attempt/pass/fail counter banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            attempt_cnt <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
        end else if (clr) begin
            attempt_cnt <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                attempt_cnt[c*CNT_W +: CNT_W] <= sat_add(attempt_cnt[c*CNT_W +: CNT_W],
                                                         PC_W'(trig[c] & enable));
                pass_cnt[c*CNT_W +: CNT_W]    <= sat_add(pass_cnt[c*CNT_W +: CNT_W], npass[c]);
                fail_cnt[c*CNT_W +: CNT_W]    <= sat_add(fail_cnt[c*CNT_W +: CNT_W],
                                                         PC_W'(fail_c[c]));
            end
        end
    end
`else
    assign attempt_cnt = '0;
    assign pass_cnt    = '0;
    assign fail_cnt    = '0;
`endif

endmodule

// File: tb/tb_resp_window_checker.sv
// Directed self-checking bench for resp_window_checker: three instances
// (window 1..1, 2..4 and 1..4 with 4-bit counters) driven by hand-built
// sequences. Counter expectations follow RESP_WINDOW_CHECKER_CNT_EN.
module tb_resp_window_checker;

`ifdef RESP_WINDOW_CHECKER_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, enable, clr;

    logic [1:0]  trig_a, resp_a, pass_a, fail_a;
    logic        fs_a;
    logic [31:0] ac_a, pc_a, fc_a;

    logic [1:0]  trig_b, resp_b, pass_b, fail_b;
    logic        fs_b;
    logic [31:0] ac_b, pc_b, fc_b;

    logic [1:0]  trig_c, resp_c, pass_c, fail_c;
    logic        fs_c;
    logic [7:0]  ac_c, pc_c, fc_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    resp_window_checker #(.CHANNELS(2), .MIN_DLY(1), .MAX_DLY(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr),
        .trig(trig_a), .resp(resp_a), .pass(pass_a), .fail(fail_a), .fail_seen(fs_a),
        .attempt_cnt(ac_a), .pass_cnt(pc_a), .fail_cnt(fc_a));

    resp_window_checker #(.CHANNELS(2), .MIN_DLY(2), .MAX_DLY(4), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr),
        .trig(trig_b), .resp(resp_b), .pass(pass_b), .fail(fail_b), .fail_seen(fs_b),
        .attempt_cnt(ac_b), .pass_cnt(pc_b), .fail_cnt(fc_b));

    resp_window_checker #(.CHANNELS(2), .MIN_DLY(1), .MAX_DLY(4), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr),
        .trig(trig_c), .resp(resp_c), .pass(pass_c), .fail(fail_c), .fail_seen(fs_c),
        .attempt_cnt(ac_c), .pass_cnt(pc_c), .fail_cnt(fc_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ce(input int unsigned v);
        return CNT_ON ? 32'(v) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; clr = 1'b0;
        trig_a = '0; resp_a = '0; trig_b = '0; resp_b = '0; trig_c = '0; resp_c = '0;
        #2;
        check("rst_pass_a", 32'(pass_a), 32'd0);
        check("rst_fail_a", 32'(fail_a), 32'd0);
        check("rst_fs_a", 32'(fs_a), 32'd0);
        check("rst_ac_a", ac_a, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Window 1..1: trig |=> resp
        trig_a = 2'b01; tick(); trig_a = '0;
        check("a_trig_pass", 32'(pass_a), 32'd0);
        check("a_trig_ac", 32'(ac_a[15:0]), ce(1));
        resp_a = 2'b01; tick(); resp_a = '0;
        check("a_pass", 32'(pass_a), 32'd1);
        check("a_pass_nofail", 32'(fail_a), 32'd0);
        check("a_pc", 32'(pc_a[15:0]), ce(1));
        check("a_fc0", 32'(fc_a[15:0]), 32'd0);
        tick();
        check("a_pass_pulse", 32'(pass_a), 32'd0);
        trig_a = 2'b01; tick(); trig_a = '0;
        tick();
        check("a_fail", 32'(fail_a), 32'd1);
        check("a_fail_nopass", 32'(pass_a), 32'd0);
        check("a_fs", 32'(fs_a), 32'd1);
        check("a_fc", 32'(fc_a[15:0]), ce(1));
        tick();
        check("a_fail_pulse", 32'(fail_a), 32'd0);
        check("a_fs_sticky", 32'(fs_a), 32'd1);

        // Window 2..4: early resp ignored, expiry at age 4
        trig_b = 2'b01; tick(); trig_b = '0;
        resp_b = 2'b01; tick(); resp_b = '0;
        check("b_early_nopass", 32'(pass_b), 32'd0);
        tick(); tick();
        check("b_age3_nofail", 32'(fail_b), 32'd0);
        tick();
        check("b_expire", 32'(fail_b), 32'd1);
        check("b_expire_nopass", 32'(pass_b), 32'd0);
        trig_b = 2'b01; tick(); trig_b = '0;
        tick(); tick();
        resp_b = 2'b01; tick(); resp_b = '0;
        check("b_pass_age3", 32'(pass_b), 32'd1);
        check("b_pass_age3_nofail", 32'(fail_b), 32'd0);
        check("b_ac", 32'(ac_b[15:0]), ce(2));
        check("b_pc", 32'(pc_b[15:0]), ce(1));
        check("b_fc", 32'(fc_b[15:0]), ce(1));
        tick();
        check("b_resolved_nofail", 32'(fail_b), 32'd0);
        // Response exactly at the last window edge passes
        trig_b = 2'b01; tick(); trig_b = '0;
        tick(); tick(); tick();
        resp_b = 2'b01; tick(); resp_b = '0;
        check("b_pass_age4", 32'(pass_b), 32'd1);
        check("b_pass_age4_nofail", 32'(fail_b), 32'd0);

        // 4-bit counter saturation on channel 1
        for (int i = 0; i < 20; i++) begin
            trig_c = 2'b10; tick(); trig_c = '0;
            resp_c = 2'b10; tick(); resp_c = '0;
        end
        check("c_sat_pass", 32'(pass_c), 32'd2);
        check("c_sat_pc1", 32'(pc_c[7:4]), ce(15));
        check("c_sat_ac1", 32'(ac_c[7:4]), ce(15));
        check("c_sat_fc1", 32'(fc_c[7:4]), 32'd0);
        check("c_sat_pc0", 32'(pc_c[3:0]), 32'd0);
        check("c_sat_ac0", 32'(ac_c[3:0]), 32'd0);
        tick();
        check("c_sat_hold", 32'(pc_c[7:4]), ce(15));

        // Window 1..4: three overlapping attempts, one resp resolves all
        trig_c = 2'b01; tick(); tick(); tick(); trig_c = '0;
        check("c_ovl_nopass", 32'(pass_c), 32'd0);
        resp_c = 2'b01; tick(); resp_c = '0;
        check("c_ovl_pass", 32'(pass_c), 32'd1);
        check("c_ovl_nofail", 32'(fail_c), 32'd0);
        check("c_ovl_pc0", 32'(pc_c[3:0]), ce(3));
        check("c_ovl_ac0", 32'(ac_c[3:0]), ce(3));
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("c_ovl_quiet%0d", i), 32'({pass_c, fail_c}), 32'd0);
        end

        // Async reset with an attempt in flight
        trig_b = 2'b01; tick(); trig_b = '0;
        tick();
        #2 rst_n = 1'b0; #1;
        check("rst_mid_fs_b", 32'(fs_b), 32'd0);
        check("rst_mid_ac_b", ac_b, 32'd0);
        check("rst_mid_pc_b", pc_b, 32'd0);
        check("rst_mid_fc_b", fc_b, 32'd0);
        check("rst_mid_pf_b", 32'({pass_b, fail_b}), 32'd0);
        check("rst_mid_fs_a", 32'(fs_a), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_after_fail%0d", i), 32'(fail_b), 32'd0);
        end

        // clr with an attempt in flight, after a real fail
        trig_b = 2'b01; tick(); trig_b = '0;
        tick(); tick(); tick(); tick();
        check("clr_pre_fail", 32'(fail_b), 32'd1);
        check("clr_pre_fs", 32'(fs_b), 32'd1);
        trig_b = 2'b01; tick(); trig_b = '0;
        check("clr_pre_ac", 32'(ac_b[15:0]), ce(2));
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_fs", 32'(fs_b), 32'd0);
        check("clr_ac", ac_b, 32'd0);
        check("clr_fc", fc_b, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("clr_after_fail%0d", i), 32'(fail_b), 32'd0);
        end

        // enable low flushes open attempts and blocks new ones, counters hold
        trig_b = 2'b01; tick();
        enable = 1'b0; tick(); enable = 1'b1; trig_b = '0;
        check("en_hold_ac", 32'(ac_b[15:0]), ce(1));
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("en_after_pf%0d", i), 32'({pass_b, fail_b}), 32'd0);
        end
        check("en_fs", 32'(fs_b), 32'd0);
        check("en_ac_final", 32'(ac_b[15:0]), ce(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
